// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32x64 register file: picks one writeback requester per cycle,
// decodes its destination to a one-hot enable and registers it. Define WB_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module regfile_write_arbiter #(
    parameter int NREQ     = 2,
    parameter int NREGS    = 32,
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*5-1:0]       req_addr,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREGS-1:0]        write_enable,
    output logic [WIDTH-1:0]        wr_data,
    output logic [4:0]              wr_addr,
    output logic [15:0]             conflict_count
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  grant_oh_s;
    logic             grant_any_s;
    logic [4:0]       sel_addr_s;
    logic [WIDTH-1:0] sel_data_s;
    logic             conflict_s;

    // Zero-register writes still complete the handshake but enable nothing.
    function automatic logic [NREGS-1:0] decode_we(input logic [4:0] addr);
        logic [NREGS-1:0] dec;
        dec = '0;
        for (int i = 0; i < NREGS; i++) begin
            dec[i] = (addr == 5'(i)) && (i != ZERO_REG);
        end
        return dec;
    endfunction

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [IDXW-1:0] last_grant_r;
    logic [IDXW-1:0] grant_idx_s;

    // Round-robin search starting just above the last granted requester.
    always_comb begin
        int idx;
        idx         = 0;
        grant_oh_s  = '0;
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        sel_addr_s  = '0;
        sel_data_s  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(last_grant_r) + 1 + k) % NREQ;
            if (!grant_any_s && req_valid[idx]) begin
                grant_any_s     = 1'b1;
                grant_oh_s[idx] = 1'b1;
                grant_idx_s     = IDXW'(idx);
                sel_addr_s      = req_addr[idx*5 +: 5];
                sel_data_s      = req_data[idx*WIDTH +: WIDTH];
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // Pointer moves only when a grant is actually issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= IDXW'(NREQ - 1);
        end else if (grant_any_s) begin
            last_grant_r <= grant_idx_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`else
    // Fixed priority: lowest-index valid requester wins.
    always_comb begin
        grant_oh_s  = '0;
        grant_any_s = 1'b0;
        sel_addr_s  = '0;
        sel_data_s  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any_s && req_valid[k]) begin
                grant_any_s   = 1'b1;
                grant_oh_s[k] = 1'b1;
                sel_addr_s    = req_addr[k*5 +: 5];
                sel_data_s    = req_data[k*WIDTH +: WIDTH];
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end
`endif

    // Grants are suppressed while reset is held so no transfer can be claimed.
    always_comb begin
        req_ready  = grant_oh_s & {NREQ{~reset}};
        conflict_s = ($countones(req_valid) > 1);
    end

    // Output stage: enable pulses for one cycle per grant, data/addr hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_enable <= '0;
            wr_data      <= '0;
            wr_addr      <= 5'd0;
        end else if (grant_any_s) begin
            write_enable <= decode_we(sel_addr_s);
            wr_data      <= sel_data_s;
            wr_addr      <= sel_addr_s;
        end else begin
            write_enable <= '0;
            wr_data      <= wr_data;
            wr_addr      <= wr_addr;
        end
    end

    // Saturating count of multi-requester cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_count <= 16'd0;
        end else if (conflict_s && (conflict_count != 16'hFFFF)) begin
            conflict_count <= conflict_count + 16'd1;
        end else begin
            conflict_count <= conflict_count;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; expectations follow WB_ARB_ROUND_ROBIN_EN when defined.
module tb_regfile_write_arbiter;

    logic          clk;
    logic          reset;
    logic [1:0]    req_valid;
    logic [9:0]    req_addr;
    logic [127:0]  req_data;
    logic [1:0]    req_ready;
    logic [31:0]   write_enable;
    logic [63:0]   wr_data;
    logic [4:0]    wr_addr;
    logic [15:0]   conflict_count;

    int total;
    int bad;

    regfile_write_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .write_enable   (write_enable),
        .wr_data        (wr_data),
        .wr_addr        (wr_addr),
        .conflict_count (conflict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [1:0]  rdy;
        logic [31:0] we;
        logic [63:0] wd;
        logic [4:0]  wa;
        logic [15:0] cc;
    } vec_t;

    vec_t vt[9];

    localparam logic [63:0] D0   = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D1   = 64'h5555_6666_7777_8888;
    localparam logic [63:0] DBEF = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] DALL = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic vec_t mk(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                                input logic [63:0] d0, input logic [63:0] d1, input logic [1:0] rdy,
                                input logic [31:0] we, input logic [63:0] wd, input logic [4:0] wa,
                                input logic [15:0] cc);
        vec_t r;
        r.valid = v; r.a0 = a0; r.a1 = a1; r.d0 = d0; r.d1 = d1;
        r.rdy = rdy; r.we = we; r.wd = wd; r.wa = wa; r.cc = cc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [63:0] d0, input logic [63:0] d1);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive(2'b00, 5'd0, 5'd0, 64'd0, 64'd0);

        vt[0] = mk(2'b00, 5'd0,  5'd0, 64'd0, 64'd0, 2'b00, 32'd0,       64'd0, 5'd0,  16'd0);
        vt[1] = mk(2'b10, 5'd0,  5'd5, 64'd0, DBEF,  2'b10, 32'd1 << 5,  DBEF,  5'd5,  16'd0);
        vt[2] = mk(2'b00, 5'd0,  5'd5, 64'd0, DBEF,  2'b00, 32'd0,       DBEF,  5'd5,  16'd0);
`ifdef WB_ARB_ROUND_ROBIN_EN
        vt[3] = mk(2'b11, 5'd3,  5'd7, D0, D1, 2'b01, 32'd1 << 3, D0, 5'd3, 16'd1);
        vt[4] = mk(2'b11, 5'd3,  5'd7, D0, D1, 2'b10, 32'd1 << 7, D1, 5'd7, 16'd2);
        vt[5] = mk(2'b11, 5'd3,  5'd7, D0, D1, 2'b01, 32'd1 << 3, D0, 5'd3, 16'd3);
        vt[6] = mk(2'b11, 5'd3,  5'd7, D0, D1, 2'b10, 32'd1 << 7, D1, 5'd7, 16'd4);
        vt[7] = mk(2'b01, 5'd31, 5'd7, DALL, D1, 2'b01, 32'd0, DALL, 5'd31, 16'd4);
        vt[8] = mk(2'b11, 5'd3,  5'd7, D0, D1, 2'b10, 32'd1 << 7, D1, 5'd7, 16'd5);
`else
        vt[3] = mk(2'b11, 5'd3,  5'd7, D0, D1, 2'b01, 32'd1 << 3, D0, 5'd3, 16'd1);
        vt[4] = mk(2'b11, 5'd3,  5'd7, D0, D1, 2'b01, 32'd1 << 3, D0, 5'd3, 16'd2);
        vt[5] = mk(2'b11, 5'd3,  5'd7, D0, D1, 2'b01, 32'd1 << 3, D0, 5'd3, 16'd3);
        vt[6] = mk(2'b11, 5'd3,  5'd7, D0, D1, 2'b01, 32'd1 << 3, D0, 5'd3, 16'd4);
        vt[7] = mk(2'b01, 5'd31, 5'd7, DALL, D1, 2'b01, 32'd0, DALL, 5'd31, 16'd4);
        vt[8] = mk(2'b11, 5'd3,  5'd7, D0, D1, 2'b01, 32'd1 << 3, D0, 5'd3, 16'd5);
`endif

        // Reset state with inputs idle, and ready gated while reset is high.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 64'(write_enable), 64'd0);
        chk("rst_wd", wr_data, 64'd0);
        chk("rst_wa", 64'(wr_addr), 64'd0);
        chk("rst_cc", 64'(conflict_count), 64'd0);
        drive(2'b11, 5'd1, 5'd2, D0, D1);
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        drive(2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table: ready sampled mid-cycle, registered outputs after the edge.
        for (int i = 0; i < 9; i++) begin
            drive(vt[i].valid, vt[i].a0, vt[i].a1, vt[i].d0, vt[i].d1);
            #1;
            chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vt[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we", i), 64'(write_enable), 64'(vt[i].we));
            chk($sformatf("v%0d_wd", i), wr_data, vt[i].wd);
            chk($sformatf("v%0d_wa", i), 64'(wr_addr), 64'(vt[i].wa));
            chk($sformatf("v%0d_cc", i), 64'(conflict_count), 64'(vt[i].cc));
            @(negedge clk);
        end

        // Grant to addr 10, then reset pulsed mid-way through the following cycle.
        drive(2'b01, 5'd10, 5'd7, D0, D1);
        @(posedge clk);
        #1;
        chk("pre_rst_we", 64'(write_enable), 64'd1 << 10);
        drive(2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_we", 64'(write_enable), 64'd0);
        chk("async_rst_cc", 64'(conflict_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(2'b11, 5'd3, 5'd7, D0, D1);
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("post_rst_we", 64'(write_enable), 64'd1 << 3);

        // Saturation: reset the counter, then hold a two-way conflict.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        @(negedge clk);
        drive(2'b11, 5'd3, 5'd7, D0, D1);
        repeat (65534) @(posedge clk);
        #1;
        chk("cc_fffe", 64'(conflict_count), 64'hFFFE);
        @(posedge clk);
        #1;
        chk("cc_sat", 64'(conflict_count), 64'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        chk("cc_hold", 64'(conflict_count), 64'hFFFF);

        drive(2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32×64-bit register file between multiple writeback requesters (ALU, load unit, …). Arbitrates each cycle, returns a grant over a valid/ready handshake, decodes the winning 5-bit destination into the one-hot per-register `write_enable` vector, and registers the result so the register file sees a clean write one cycle later. Sits between the writeback stage and the register-file array.

## Interface

Parameters:
- `NREQ`, 2: number of requesters.
- `NREGS`, 32: registers in the file, one write-enable line each.
- `WIDTH`, 64: data width.
- `ZERO_REG`, 31: hard-wired zero register index; writes to it are discarded.

Ports:
- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req_valid`  in  NREQ  requester i has a write pending.
- `req_addr`  in  NREQ×5  destination index, requester i at bits [5i+4:5i].
- `req_data`  in  NREQ×WIDTH  write data, requester i at [WIDTH·i+WIDTH-1:WIDTH·i].
- `req_ready`  out  NREQ  one-hot grant; transfer occurs when `req_valid[i] & req_ready[i]`.
- `write_enable`  out  NREGS  registered one-hot per-register enable, zero when idle.
- `wr_data`  out  WIDTH  registered data for the register file.
- `wr_addr`  out  5  registered destination index, for forwarding and debug.
- `conflict_count`  out  16  saturating count of cycles with more than one `req_valid` high.

## Operation

- At most one grant per cycle; `req_ready` is combinational from `req_valid` and the priority pointer. It is never asserted for a requester whose `req_valid` is low.
- Arbitration is round-robin:
  - Priority begins at `(last_grant+1) mod NREQ` and searches upward with wrap-around.
  - `last_grant` updates only in cycles where a grant is issued.
  - Reset value of `last_grant` is NREQ-1, so requester 0 has first priority.
- On a grant, the output stage captures:
  - `wr_data` ← granted `req_data`
  - `wr_addr` ← granted `req_addr`
  - `write_enable` ← one-hot decode of `req_addr`
- With no grant, `write_enable` returns to 0 at the next edge. `wr_data` and `wr_addr` hold their last values.
- A grant with `req_addr == ZERO_REG` is accepted and advances the pointer. The captured `write_enable` is all zeros, so no register is written.
- A requester must hold `req_valid`, `req_addr` and `req_data` stable until it is granted. Dropping `req_valid` before the grant withdraws the request, with no side effect.
- `conflict_count` increments on every cycle where two or more `req_valid` bits are set. It saturates at 0xFFFF.
- Reset values: `write_enable`=0, `wr_data`=0, `wr_addr`=0, `conflict_count`=0, `last_grant`=NREQ-1. `req_ready` evaluates to 0 while `reset` is high.

## Timing

- Cycle N: request valid and granted; `req_ready` is high combinationally.
- Edge ending N: output stage loads. `write_enable`, `wr_data` and `wr_addr` are visible during N+1.
- Edge ending N+1: the register file latches. Total request-to-stored latency is 2 edges.
- Throughput: one write per cycle. Back-to-back grants produce back-to-back one-hot enables with no bubble.
- Reset asserted mid-operation: any write captured in the output stage is dropped immediately, so `write_enable` goes to 0 asynchronously. The pending requester is not considered granted and must re-present its request.
- Simultaneous requests to the same destination: the one granted later wins, because its write lands one cycle later.

## Configuration

- `WB_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration as described above.
- Not defined: fixed priority, where the lowest index wins. `last_grant` is not implemented. All other behaviour, including `conflict_count` and zero-register discard, is unchanged.

## Test plan

- Reset with all inputs 0: `write_enable`=0, `wr_data`=0, `wr_addr`=0, `conflict_count`=0, `req_ready`=0.
- Single request, requester 1, addr=5, data=0xDEADBEEF_00000001: `req_ready`=2'b10 in the same cycle. Next cycle `write_enable`=1<<5, `wr_data`=0xDEADBEEF_00000001, `wr_addr`=5. The cycle after, `write_enable`=0.
- Both requesters held valid for 4 cycles (addr 3 and 7), with the round-robin macro defined:
  - Grants alternate 0,1,0,1.
  - `write_enable` sequence is 1<<3, 1<<7, 1<<3, 1<<7.
  - `conflict_count`=4.
  - Repeat without the macro: requester 0 is granted all 4 cycles.
- Request to addr 31 with data 0xFFFF_FFFF_FFFF_FFFF: `req_ready` is high, the next-cycle `write_enable`=0, and the pointer has advanced (a subsequent two-way conflict grants the other requester).
- Grant at cycle N to addr 10, `reset` pulsed during N+1: `write_enable` drops to 0 asynchronously, and after reset release requester 0 has priority.
- Force 65,540 conflict cycles: `conflict_count` saturates at 0xFFFF and holds.
